// File: rtl/uart_arb_pkg.sv
// ============================================================================
// uart_arb_pkg : shared state encoding and defaults for uart_msg_arbiter
// Revision     : 1.0
// ============================================================================
`default_nettype none

package uart_arb_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        SEND    = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_msg_arbiter_rr_pick.sv
// ============================================================================
// rr_pick  : combinational round-robin picker, first requester after last_ptr
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] last_ptr,
    output logic [N-1:0]     pick,
    output logic             found
);

    int               sum;
    logic [PTR_W-1:0] idx;

    // Offsets 1..N scan every requester once, ending on last_ptr itself.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        sum   = 0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            sum = int'(last_ptr) + k;
            idx = PTR_W'(sum % N);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_msg_arbiter.sv
// ============================================================================
// uart_msg_arbiter : round-robin, message-atomic sharing of one uart_tx.
// Optional watchdog on tx_done enabled by macro UART_ARB_TIMEOUT_EN.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module uart_msg_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    clk_3125KHz,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        byte_valid,
    input  logic [N_REQ*DATA_W-1:0] byte_data,
    input  logic [N_REQ-1:0]        byte_last,
    output logic [N_REQ-1:0]        byte_ready,
    output logic [N_REQ-1:0]        grant,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       msg,
    input  logic                    tx_done,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int PTR_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("uart_msg_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC at least 2");
    end

    arb_state_t       state;
    logic [PTR_W-1:0] last_ptr;
    logic [PTR_W-1:0] owner;
    logic             last_q;
    logic [N_REQ-1:0] pick;
    logic             found;
    logic [PTR_W-1:0] pick_idx;

    rr_pick #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req      (req),
        .last_ptr (last_ptr),
        .pick     (pick),
        .found    (found)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
    end

    assign busy = |grant;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] wd_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_ptr   <= PTR_W'(N_REQ - 1);
            owner      <= '0;
            last_q     <= 1'b0;
            grant      <= '0;
            byte_ready <= '0;
            tx_start   <= 1'b0;
            msg        <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            byte_ready <= '0;
            tx_start   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= pick;
                        owner <= pick_idx;
                        state <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (!req[owner]) begin
                        grant    <= '0;
                        last_ptr <= owner;
                        state    <= IDLE;
                    end else if (byte_valid[owner]) begin
                        msg               <= byte_data[int'(owner)*DATA_W +: DATA_W];
                        last_q            <= byte_last[owner];
                        byte_ready[owner] <= 1'b1;
                        tx_start          <= 1'b1;
                        state             <= SEND;
`ifdef UART_ARB_TIMEOUT_EN
                        wd_cnt            <= '0;
`endif
                    end
                end
                SEND: begin
                    // A dropped req only takes effect once the in-flight byte completes.
                    if (tx_done) begin
                        if (last_q || !req[owner]) begin
                            grant    <= '0;
                            last_ptr <= owner;
                            state    <= IDLE;
                        end else begin
                            state <= GRANTED;
                        end
`ifdef UART_ARB_TIMEOUT_EN
                    end else if (wd_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        timeout_err <= 1'b1;
                        grant       <= '0;
                        last_ptr    <= owner;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_msg_arbiter.sv
// ============================================================================
// tb_uart_msg_arbiter : scoreboard bench for uart_msg_arbiter
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_uart_msg_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    byte_valid;
    logic [N*DW-1:0] byte_data;
    logic [N-1:0]    byte_last;
    logic [N-1:0]    byte_ready;
    logic [N-1:0]    grant;
    logic            tx_start;
    logic [DW-1:0]   msg;
    logic            tx_done;
    logic            busy;
    logic            timeout_err;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    always #10 clk = ~clk;

    uart_msg_arbiter #(
        .N_REQ       (N),
        .DATA_W      (DW),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk_3125KHz (clk),
        .rst_n       (rst_n),
        .req         (req),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_last   (byte_last),
        .byte_ready  (byte_ready),
        .grant       (grant),
        .tx_start    (tx_start),
        .msg         (msg),
        .tx_done     (tx_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_grant(input int id);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == '0 && n < 50);
        check_val("grant_lat", n, 1);
        check_val("grant", grant, 32'(1) << id);
        check_val("busy", busy, 1);
    endtask

    task automatic xfer(input int id, input logic [DW-1:0] d, input logic last,
                        input logic drop_in_send, input logic expect_release);
        int n;
        byte_valid[id]          = 1'b1;
        byte_data[id*DW +: DW]  = d;
        byte_last[id]           = last;
        exp_q.push_back(d);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start && n < 8);
        check_val("tx_start_lat", n, 1);
        check_val("byte_ready", byte_ready, 32'(1) << id);
        if (exp_q.size() > 0) check_val("msg", msg, exp_q.pop_front());
        byte_valid[id] = 1'b0;
        byte_last[id]  = 1'b0;
        if (drop_in_send) req[id] = 1'b0;
        @(negedge clk);
        check_val("start_pulse", {tx_start, byte_ready}, 0);
        repeat (18) @(negedge clk);
        check_val("grant_send", grant, 32'(1) << id);
        check_val("msg_hold", msg, d);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_val("grant_after", grant, expect_release ? 32'(0) : (32'(1) << id));
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = '0;
        byte_valid = '0;
        byte_data  = '0;
        byte_last  = '0;
        tx_done    = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_outs", {grant, byte_ready, tx_start, msg, busy, timeout_err}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fairness from reset: all requesting, 1-byte messages.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(k % N);
            xfer(k % N, DW'(8'h10 + k), 1'b1, 1'b0, 1'b1);
        end
        req = '0;
        @(negedge clk);

        // Three-byte message from requester 2.
        req[2] = 1'b1;
        wait_grant(2);
        xfer(2, 8'h41, 1'b0, 1'b0, 1'b0);
        xfer(2, 8'h42, 1'b0, 1'b0, 1'b0);
        xfer(2, 8'h43, 1'b1, 1'b0, 1'b1);
        req[2] = 1'b0;
        @(negedge clk);

        // Atomicity: requester 0 waits for requester 1's whole message.
        req[1] = 1'b1;
        wait_grant(1);
        req[0] = 1'b1;
        xfer(1, 8'hA1, 1'b0, 1'b0, 1'b0);
        xfer(1, 8'hA2, 1'b1, 1'b0, 1'b1);
        req[1] = 1'b0;
        wait_grant(0);
        xfer(0, 8'hB0, 1'b1, 1'b0, 1'b1);
        req[0] = 1'b0;
        @(negedge clk);

        // Abort in GRANTED; stray tx_done must be ignored first.
        req[3] = 1'b1;
        wait_grant(3);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_val("stray_done", {grant, tx_start}, {4'b1000, 1'b0});
        req[3] = 1'b0;
        @(negedge clk);
        check_val("abort_granted", {grant, tx_start}, 0);
        @(negedge clk);

        // Drop in SEND: byte completes, then release.
        req[3] = 1'b1;
        wait_grant(3);
        xfer(3, 8'h55, 1'b0, 1'b1, 1'b1);
        @(negedge clk);

        // Reset in the middle of SEND.
        req[2] = 1'b1;
        wait_grant(2);
        byte_valid[2]        = 1'b1;
        byte_data[2*DW +: DW] = 8'h77;
        @(negedge clk);
        check_val("pre_rst_start", tx_start, 1);
        byte_valid[2] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_outs", {grant, byte_ready, tx_start, msg, busy, timeout_err}, 0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req = 4'b0001;
        wait_grant(0);
        req = '0;
        @(negedge clk);
        check_val("post_rst_abort", grant, 0);

`ifdef UART_ARB_TIMEOUT_EN
        begin
            int n;
            req[1] = 1'b1;
            wait_grant(1);
            byte_valid[1]         = 1'b1;
            byte_data[1*DW +: DW] = 8'hEE;
            @(negedge clk);
            check_val("to_start", tx_start, 1);
            byte_valid[1] = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!timeout_err && n < 40);
            check_val("timeout_lat", n, 16);
            check_val("timeout_grant", grant, 0);
            req[1] = 1'b0;
            @(negedge clk);
            check_val("timeout_pulse", timeout_err, 0);
        end
`else
        check_val("timeout_tied", timeout_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/uart_msg_arbiter.md
# uart_msg_arbiter

Round-robin arbiter that shares the single Bluetooth `uart_tx` instance between several message producers (colour report, node report, finish report, spare). Each requester owns the transmitter for a whole multi-byte message, so bytes from different producers never interleave. The arbiter sequences bytes to the UART by pulsing `tx_start` with `msg` and waiting for `tx_done`. It sits between the producers and `uart_tx` in the top level, on the 3125 kHz domain.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 8, byte width presented to `uart_tx`
- `TIMEOUT_CYC`, 4096, cycles to wait for `tx_done` before abort (used only with the macro)

- `clk_3125KHz`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  requester i wants the UART; held high for the whole message
- `byte_valid`  in  N_REQ  requester i presents a byte
- `byte_data`  in  N_REQ*DATA_W  flattened bytes; requester i at [i*DATA_W +: DATA_W]
- `byte_last`  in  N_REQ  presented byte is the final byte of the message
- `byte_ready`  out  N_REQ  one-cycle pulse: byte of requester i accepted
- `grant`  out  N_REQ  one-hot owner, or all-zero
- `tx_start`  out  1  one-cycle pulse to `uart_tx`
- `msg`  out  DATA_W  byte to `uart_tx`; stable from `tx_start` until `tx_done`
- `tx_done`  in  1  `uart_tx` byte-complete pulse
- `busy`  out  1  high whenever `grant` is non-zero
- `timeout_err`  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, GRANTED, SEND.
- IDLE: if any `req` is high, pick the first requester after `last_ptr` (wrapping) with `req` high. Register it into `grant`. Go to GRANTED.
- GRANTED, owner g:
  - `req[g]` low: clear grant, set `last_ptr`=g, go to IDLE (abort with no byte in flight).
  - Else if `byte_valid[g]`: latch `byte_data[g]` into `msg` and `byte_last[g]` into `last_q`. Pulse `byte_ready[g]` and `tx_start`. Go to SEND.
- SEND:
  - On `tx_done`: if `last_q` or `req[g]` is low, clear grant, set `last_ptr`=g, go to IDLE. Otherwise return to GRANTED.
  - A `req[g]` drop during SEND does not abort; the byte completes first.
- Inputs of non-owners are ignored. `tx_done` outside SEND is ignored.
- `last_ptr` resets to N_REQ-1, so requester 0 wins the first arbitration.
- Reset values: `grant`=0, `byte_ready`=0, `tx_start`=0, `msg`=0, `busy`=0, `timeout_err`=0, state IDLE, `last_ptr`=N_REQ-1.
- Asserting reset mid-message drops the message immediately. No resume after reset.

## Timing
- `req` high at edge t (IDLE) -> `grant` high after edge t+1.
- `byte_valid[g]` high at edge t (GRANTED) -> `byte_ready[g]`, `tx_start`, `msg` valid after edge t+1, all registered.
- A producer holds each byte until it sees `byte_ready`, then presents the next byte or drops `byte_valid`.
- `tx_done` at edge t -> GRANTED or IDLE after t+1.
- Back-to-back messages need at least one IDLE cycle between grants.
- Minimum per-byte overhead: 2 cycles plus UART frame time.

## Configuration
- `UART_ARB_TIMEOUT_EN`, when defined:
  - A counter clears on `tx_start` and increments in SEND.
  - Reaching `TIMEOUT_CYC`-1 without `tx_done` pulses `timeout_err`, clears grant, sets `last_ptr`=g and returns to IDLE.
- When undefined: no counter, `timeout_err` tied 0, and SEND waits for `tx_done` indefinitely.

## Structure
- Package `uart_arb_pkg`: state enum (IDLE/GRANTED/SEND) and the default `DATA_W` constant.
- Sub-module `rr_pick`: combinational round-robin picker; inputs `req` and `last_ptr`, outputs a one-hot pick and a found flag.

## Test plan
- Reset: `rst_n` low mid-SEND -> all outputs 0 immediately. After release, `req`=4'b0001 -> `grant`=4'b0001 one cycle later.
- Single message: requester 2 sends 0x41, 0x42, 0x43 with `byte_last` on 0x43. Each `tx_done` 20 cycles after `tx_start`. Expect 3 `tx_start` pulses with `msg` 0x41/0x42/0x43, 3 `byte_ready[2]` pulses, then `grant`=0.
- Fairness: `req`=4'b1111 with 1-byte messages -> grant order 0,1,2,3,0.
- Atomicity: requester 1 starts a 2-byte message while requester 0 is requesting -> requester 0 gets no grant until requester 1's last `tx_done`.
- Abort: `req[3]` drops in GRANTED -> IDLE next cycle, no `tx_start`. `req[3]` drops in SEND -> byte finishes on `tx_done`, then release.
- With `UART_ARB_TIMEOUT_EN` and `TIMEOUT_CYC`=16, `tx_done` never asserted -> `timeout_err` pulse 16 cycles after `tx_start`, `grant`=0.
